// File: rtl/serial_word_deserializer_pkg.sv
// Shared constants and types for the serial word deserializer:
// bit-order selectors and the holding-register state encoding.
package serial_word_deserializer_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam bit BIT_ORDER_MSB_FIRST = 1'b1;
  localparam bit BIT_ORDER_LSB_FIRST = 1'b0;

  typedef enum logic {
    HOLD_EMPTY = 1'b0,
    HOLD_FULL  = 1'b1
  } hold_state_e;

endpackage

// File: rtl/serial_word_deserializer_if.sv
// Bit-stream input, word valid/ready output and status signals of the deserializer.
// The master modport belongs to the stream producer and word consumer; the slave modport belongs to the deserializer.
interface serial_word_deserializer_if
  import serial_word_deserializer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CW    = $clog2(WIDTH)
);

  logic             bit_in;
  logic             bit_valid;
  logic             clear;
  logic             word_ready;
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic [CW-1:0]    bit_count;
  logic             overrun;

  modport master (
    output bit_in, bit_valid, clear, word_ready,
    input  word_out, word_valid, bit_count, overrun
  );

  modport slave (
    input  bit_in, bit_valid, clear, word_ready,
    output word_out, word_valid, bit_count, overrun
  );

endinterface

// File: rtl/serial_word_deserializer_word_holding_reg.sv
// One-entry output register with a valid/ready handshake and a sticky overrun flag.
// A word completing while the register is full and not being accepted is dropped.
module word_holding_reg
  import serial_word_deserializer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             complete,
  input  logic [WIDTH-1:0] new_word,
  input  logic             word_ready,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  output logic             overrun
);

  hold_state_e      state_q, state_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             overrun_q, overrun_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= HOLD_EMPTY;
      word_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      overrun_q <= overrun_d;
    end
  end

  // An accept and a completion on the same edge swap in the new word without a bubble.
  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    overrun_d = overrun_q;
    case (state_q)
      HOLD_EMPTY: begin
        if (complete) begin
          state_d = HOLD_FULL;
          word_d  = new_word;
        end
      end
      HOLD_FULL: begin
        if (complete) begin
          if (word_ready) word_d = new_word;
          else            overrun_d = 1'b1;
        end else if (word_ready) begin
          state_d = HOLD_EMPTY;
        end
      end
      default: state_d = HOLD_EMPTY;
    endcase
    if (clear) overrun_d = 1'b0;
  end

  always_comb begin
    word_valid = (state_q == HOLD_FULL);
    word_out   = word_q;
    overrun    = overrun_q;
  end

endmodule

// File: rtl/serial_word_deserializer.sv
// Assembles a strobed serial bit stream into WIDTH-bit words and hands them to a
// one-entry holding register. MSB_FIRST selects which end of the word the first bit lands in.
module serial_word_deserializer
  import serial_word_deserializer_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = BIT_ORDER_MSB_FIRST,
  parameter int CW        = $clog2(WIDTH)
) (
  input logic                  clk,
  input logic                  reset,
  serial_word_deserializer_if.slave bus
);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] shifted;
  logic             complete;

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q    <= '0;
      count_q <= '0;
    end else begin
      sr_q    <= sr_d;
      count_q <= count_d;
    end
  end

  // clear wins over a strobe on the same edge, so that bit is discarded.
  always_comb begin
    shifted  = (MSB_FIRST == BIT_ORDER_MSB_FIRST) ? {sr_q[WIDTH-2:0], bus.bit_in}
                                                  : {bus.bit_in, sr_q[WIDTH-1:1]};
    sr_d     = sr_q;
    count_d  = count_q;
    complete = 1'b0;
    if (bus.clear) begin
      sr_d    = '0;
      count_d = '0;
    end else if (bus.bit_valid) begin
      sr_d = shifted;
      if (count_q == CW'(WIDTH - 1)) begin
        count_d  = '0;
        complete = 1'b1;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  assign bus.bit_count = count_q;

  word_holding_reg #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk       (clk),
    .reset     (reset),
    .clear     (bus.clear),
    .complete  (complete),
    .new_word  (shifted),
    .word_ready(bus.word_ready),
    .word_out  (bus.word_out),
    .word_valid(bus.word_valid),
    .overrun   (bus.overrun)
  );

endmodule

// File: tb/tb_serial_word_deserializer.sv
// Directed bench for serial_word_deserializer: one MSB-first and one LSB-first
// instance share the same stimulus, and each step is checked against hand-computed values.
module tb_serial_word_deserializer;
  import serial_word_deserializer_pkg::*;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  serial_word_deserializer_if #(.WIDTH(8)) msb_if ();
  serial_word_deserializer_if #(.WIDTH(8)) lsb_if ();

  serial_word_deserializer #(
    .WIDTH(8), .MSB_FIRST(BIT_ORDER_MSB_FIRST)
  ) dut_msb (
    .clk  (clk),
    .reset(reset),
    .bus  (msb_if.slave)
  );

  serial_word_deserializer #(
    .WIDTH(8), .MSB_FIRST(BIT_ORDER_LSB_FIRST)
  ) dut_lsb (
    .clk  (clk),
    .reset(reset),
    .bus  (lsb_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive both instances identically, let one rising edge pass, then settle before sampling.
  task automatic step(input logic bi, input logic bv, input logic cl, input logic rdy);
    msb_if.bit_in     = bi;
    msb_if.bit_valid  = bv;
    msb_if.clear      = cl;
    msb_if.word_ready = rdy;
    lsb_if.bit_in     = bi;
    lsb_if.bit_valid  = bv;
    lsb_if.clear      = cl;
    lsb_if.word_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Strobe the 8 bits of w, most significant first, on consecutive cycles.
  task automatic send_word(input logic [7:0] w, input logic rdy_rest, input logic rdy_last);
    for (int i = 7; i >= 1; i--) step(w[i], 1'b1, 1'b0, rdy_rest);
    step(w[0], 1'b1, 1'b0, rdy_last);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end
    check("reset_word_out", 32'(msb_if.word_out), 32'h00);
    check("reset_word_valid", 32'(msb_if.word_valid), 32'h0);
    check("reset_bit_count", 32'(msb_if.bit_count), 32'h0);
    check("reset_overrun", 32'(msb_if.overrun), 32'h0);
    check("reset_lsb_valid", 32'(lsb_if.word_valid), 32'h0);
    reset = 1'b0;

    // Basic word: 1,0,1,1,0,0,1,0 with the consumer always ready.
    for (int i = 7; i >= 1; i--) step(i[0] ? 1'b0 : 1'b0, 1'b0, 1'b0, 1'b1);
    check("idle_no_count", 32'(msb_if.bit_count), 32'h0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    check("basic_count7", 32'(msb_if.bit_count), 32'h7);
    check("basic_not_yet_valid", 32'(msb_if.word_valid), 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    check("basic_valid", 32'(msb_if.word_valid), 32'h1);
    check("basic_msb_word", 32'(msb_if.word_out), 32'hB2);
    check("basic_lsb_word", 32'(lsb_if.word_out), 32'h4D);
    check("basic_count_wrap", 32'(msb_if.bit_count), 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("basic_valid_one_cycle", 32'(msb_if.word_valid), 32'h0);
    check("basic_word_retained", 32'(msb_if.word_out), 32'hB2);

    // Backpressure: B2 held, then eight 1s are dropped.
    send_word(8'hB2, 1'b0, 1'b0);
    check("bp_valid", 32'(msb_if.word_valid), 32'h1);
    check("bp_no_overrun_yet", 32'(msb_if.overrun), 32'h0);
    send_word(8'hFF, 1'b0, 1'b0);
    check("bp_word_stable", 32'(msb_if.word_out), 32'hB2);
    check("bp_lsb_word_stable", 32'(lsb_if.word_out), 32'h4D);
    check("bp_overrun", 32'(msb_if.overrun), 32'h1);
    check("bp_lsb_overrun", 32'(lsb_if.overrun), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("bp_accept_drops_valid", 32'(msb_if.word_valid), 32'h0);
    check("bp_overrun_sticky", 32'(msb_if.overrun), 32'h1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("bp_clear_overrun", 32'(msb_if.overrun), 32'h0);

    // Accept and complete on the same edge.
    send_word(8'hA5, 1'b0, 1'b0);
    check("sim_a5_pending", 32'(msb_if.word_out), 32'hA5);
    send_word(8'h3C, 1'b0, 1'b1);
    check("sim_word_3c", 32'(msb_if.word_out), 32'h3C);
    check("sim_lsb_word_3c", 32'(lsb_if.word_out), 32'h3C);
    check("sim_valid_stays", 32'(msb_if.word_valid), 32'h1);
    check("sim_no_overrun", 32'(msb_if.overrun), 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("sim_drained", 32'(msb_if.word_valid), 32'h0);

    // clear after 5 bits, with a strobe on the same edge that must be dropped.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
    check("clr_count5", 32'(msb_if.bit_count), 32'h5);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    check("clr_count0", 32'(msb_if.bit_count), 32'h0);
    check("clr_no_valid", 32'(msb_if.word_valid), 32'h0);
    send_word(8'h3C, 1'b1, 1'b1);
    check("clr_word_3c", 32'(msb_if.word_out), 32'h3C);
    check("clr_lsb_word_3c", 32'(lsb_if.word_out), 32'h3C);
    check("clr_valid", 32'(msb_if.word_valid), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Reset with a pending word, a set overrun and 3 bits of a partial word.
    send_word(8'hB2, 1'b0, 1'b0);
    send_word(8'h11, 1'b0, 1'b0);
    check("rst_pre_overrun", 32'(msb_if.overrun), 32'h1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    check("rst_pre_count3", 32'(msb_if.bit_count), 32'h3);
    reset = 1'b1;
    step(1'b1, 1'b1, 1'b0, 1'b0);
    reset = 1'b0;
    check("rst_word_out", 32'(msb_if.word_out), 32'h00);
    check("rst_word_valid", 32'(msb_if.word_valid), 32'h0);
    check("rst_bit_count", 32'(msb_if.bit_count), 32'h0);
    check("rst_overrun", 32'(msb_if.overrun), 32'h0);
    check("rst_lsb_word_out", 32'(lsb_if.word_out), 32'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
